// File: rtl/alu_defs.sv
// Shared ALU definitions: control codes (also decoded by the ALU), ALUOp
// classes, R-type funct values, sequencer FSM states and the decode helper.
package alu_defs;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ADDI  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_RUN  = 2'd1,
        ST_MUL_DONE = 2'd2
    } seq_state_e;

    // Main-control op class plus funct -> ALU control code. Unknown funct
    // values fall back to ADD so a bad encoding never produces X control.
    function automatic alu_ctrl_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_ctrl_e c;
        c = ALU_ADD;
        if (aluop == ALUOP_SUB) begin
            c = ALU_SUB;
        end else if (aluop == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_ADD: c = ALU_ADD;
                FUNCT_SUB: c = ALU_SUB;
                FUNCT_AND: c = ALU_AND;
                FUNCT_OR:  c = ALU_OR;
                FUNCT_MUL: c = ALU_MUL;
                default:   c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ID/EX -> EX issue bus: instruction/operands in, ALU control, stall and
// multiply result out. master = pipeline side, slave = sequencer.
interface alu_op_sequencer_if;
    logic        valid_i;
    logic        flush_i;
    logic [1:0]  ALUOp_i;
    logic [5:0]  funct_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [2:0]  ALUCtrl_o;
    logic        stall_o;
    logic [31:0] mul_data_o;
    logic        sel_mul_o;

    modport master (
        output valid_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
        input  ALUCtrl_o, stall_o, mul_data_o, sel_mul_o
    );

    modport slave (
        input  valid_i, flush_i, ALUOp_i, funct_i, data1_i, data2_i,
        output ALUCtrl_o, stall_o, mul_data_o, sel_mul_o
    );
endinterface

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath: retires BITS_PER_CYCLE multiplier
// bits per step into a wrapping DATA_W-bit accumulator.
// MUL_EARLY_TERM_EN: flag the last step as soon as the remaining multiplier
// bits are all zero instead of always running DATA_W/BITS_PER_CYCLE steps.
module mul_shift_add #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int DATA_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              last_o
);
    localparam int MUL_CYCLES = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] partial;

    // Partial product of the low multiplier bits, then load / step / hold
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers, cleared by reset even mid-multiply
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign acc_o = acc_q;

`ifdef MUL_EARLY_TERM_EN
    // Nothing left to add once the shifted-out multiplier is zero
    assign last_o = (cnt_q == CNT_W'(MUL_CYCLES - 1)) || ((mplier_q >> BITS_PER_CYCLE) == '0);
`else
    assign last_o = (cnt_q == CNT_W'(MUL_CYCLES - 1));
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// EX-stage ALU issue: decodes ALUOp/funct to the ALU control code and runs
// MUL as a multi-cycle shift-add, stalling the pipe until the product is
// presented with a one-cycle result-select strobe.
// Optional MUL_EARLY_TERM_EN (in mul_shift_add) shortens the run phase.
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int DATA_W         = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    alu_op_sequencer_if.slave bus
);
    seq_state_e        state_q, state_d;
    alu_ctrl_e         ctrl;
    logic              start;
    logic              last;
    logic              sel;
    logic [DATA_W-1:0] acc;

    // Decode is purely combinational and stays visible through a multiply
    always_comb ctrl = decode_alu(bus.ALUOp_i, bus.funct_i);

    // Start is gated by reset so the stall drops the instant reset asserts
    assign start = (state_q == ST_IDLE) && bus.valid_i && (ctrl == ALU_MUL)
                   && !bus.flush_i && !rst_i;

    // Next-state: DONE always returns to IDLE so a MUL still held on the
    // inputs is not re-issued in the same cycle; flush abandons the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_MUL_RUN;
            ST_MUL_RUN:  if (bus.flush_i) state_d = ST_IDLE;
                         else if (last) state_d = ST_MUL_DONE;
            ST_MUL_DONE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    mul_shift_add #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE),
        .DATA_W        (DATA_W)
    ) u_mul (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(start),
        .step_i(state_q == ST_MUL_RUN),
        .a_i   (bus.data1_i),
        .b_i   (bus.data2_i),
        .acc_o (acc),
        .last_o(last)
    );

    assign sel            = (state_q == ST_MUL_DONE) && !bus.flush_i;
    assign bus.ALUCtrl_o  = ctrl;
    assign bus.stall_o    = start || (state_q == ST_MUL_RUN);
    assign bus.sel_mul_o  = sel;
    assign bus.mul_data_o = sel ? acc : '0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: decode vector table, directed multi-cycle
// multiply/flush/reset sequences and randomized multiplies against a
// product/latency reference model.
module tb_alu_op_sequencer;
    localparam int BPC        = 1;
    localparam int MUL_CYCLES = 32 / BPC;

    logic clk = 1'b0;
    logic rst;
    int   vec  = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.BITS_PER_CYCLE(BPC), .DATA_W(32)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic       valid;
        logic       flush;
        logic [1:0] op;
        logic [5:0] f;
        logic [2:0] ctrl;
        logic       stall;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode, written from the op-class / funct table
    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 3'b001;
        if (op != 2'b10) return 3'b000;
        case (f)
            6'h20:   return 3'b000;
            6'h22:   return 3'b001;
            6'h24:   return 3'b010;
            6'h25:   return 3'b011;
            6'h18:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Number of run cycles for multiplier b
    function automatic int ref_run(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int msb;
        if (b == 0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return (msb + BPC) / BPC;
`else
        return MUL_CYCLES + 0 * int'(b[0]);
`endif
    endfunction

    task automatic drive(input logic v, input logic fl, input logic [1:0] op, input logic [5:0] f);
        bus.valid_i = v;
        bus.flush_i = fl;
        bus.ALUOp_i = op;
        bus.funct_i = f;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a MUL in the current (IDLE) cycle and follow it to its DONE cycle.
    // Ends sampled inside the DONE cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          n;
        logic        sel_seen;
        p = {32'h0, a} * {32'h0, b};
        drive(1'b1, 1'b0, 2'b10, 6'b011000);
        bus.data1_i = a;
        bus.data2_i = b;
        #1;
        chk("issue_sel", bus.sel_mul_o, 1'b0);
        n = 0;
        sel_seen = 1'b0;
        while (bus.stall_o === 1'b1 && n < 200) begin
            if (bus.sel_mul_o !== 1'b0) sel_seen = 1'b1;
            n++;
            @(posedge clk);
            #1;
            bus.data1_i = $urandom;
            bus.data2_i = $urandom;
            #1;
        end
        chk("sel_during_stall", sel_seen, 1'b0);
        chk("stall_len", n, ref_run(b) + 1);
        chk("done_sel", bus.sel_mul_o, 1'b1);
        chk("product", bus.mul_data_o, p[31:0]);
        chk("done_ctrl", bus.ALUCtrl_o, 3'b100);
    endtask

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic sel_seen;
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 6'b011000, 3'b000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, 6'b100000, 3'b001, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'b11, 6'b100010, 3'b000, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b10, 6'b100000, 3'b000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b10, 6'b100010, 3'b001, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 2'b10, 6'b100100, 3'b010, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 2'b10, 6'b100101, 3'b011, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 2'b10, 6'b111111, 3'b000, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 2'b10, 6'b011001, 3'b000, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'b10, 6'b011000, 3'b100, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2'b10, 6'b011000, 3'b100, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 6'b000000, 3'b000, 1'b0};

        // Reset state
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 6'b100100);
        bus.data1_i = 32'h0;
        bus.data2_i = 32'h0;
        #12;
        chk("rst_stall", bus.stall_o, 1'b0);
        chk("rst_sel", bus.sel_mul_o, 1'b0);
        chk("rst_data", bus.mul_data_o, 32'h0);
        chk("rst_ctrl", bus.ALUCtrl_o, 3'b010);
        rst = 1'b0;

        // Decode table, including MUL encodings that must not start
        foreach (tbl[i]) begin
            next_cycle();
            drive(tbl[i].valid, tbl[i].flush, tbl[i].op, tbl[i].f);
            #1;
            chk($sformatf("tbl%0d_ctrl", i), bus.ALUCtrl_o, tbl[i].ctrl);
            chk($sformatf("tbl%0d_stall", i), bus.stall_o, tbl[i].stall);
            chk($sformatf("tbl%0d_sel", i), bus.sel_mul_o, 1'b0);
        end

        // Directed multiplies
        next_cycle();
        run_mul(32'h7, 32'h6);
        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 6'h0);
        #1;
        chk("after_done_sel", bus.sel_mul_o, 1'b0);
        chk("after_done_stall", bus.stall_o, 1'b0);
        next_cycle();
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        next_cycle();
        run_mul(32'h5, 32'h1);
        // Back-to-back: second MUL issued in the IDLE cycle right after DONE
        next_cycle();
        run_mul(32'h3, 32'h4);
        next_cycle();
        run_mul(32'h0001_0000, 32'h0001_0000);

        // Flush in cycle 10 of a multiply
        next_cycle();
        drive(1'b1, 1'b0, 2'b10, 6'b011000);
        bus.data1_i = 32'h9;
        bus.data2_i = 32'hFFFF_FFFF;
        for (int c = 2; c <= 10; c++) next_cycle();
        bus.flush_i = 1'b1;
        #1;
        chk("flush_cyc_sel", bus.sel_mul_o, 1'b0);
        chk("flush_cyc_stall", bus.stall_o, 1'b1);
        next_cycle();
        drive(1'b0, 1'b0, 2'b10, 6'b011000);
        #1;
        chk("post_flush_stall", bus.stall_o, 1'b0);
        sel_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            next_cycle();
            if (bus.sel_mul_o !== 1'b0 || bus.stall_o !== 1'b0) sel_seen = 1'b1;
        end
        chk("post_flush_quiet", sel_seen, 1'b0);

        // Asynchronous reset mid-multiply
        next_cycle();
        drive(1'b1, 1'b0, 2'b10, 6'b011000);
        bus.data1_i = 32'h1234;
        bus.data2_i = 32'hFFFF_FFFF;
        for (int c = 2; c <= 15; c++) next_cycle();
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_stall", bus.stall_o, 1'b0);
        chk("async_rst_sel", bus.sel_mul_o, 1'b0);
        chk("async_rst_data", bus.mul_data_o, 32'h0);
        chk("async_rst_ctrl", bus.ALUCtrl_o, 3'b100);
        next_cycle();
        chk("rst_hold_stall", bus.stall_o, 1'b0);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 6'h0);
        next_cycle();
        run_mul(32'h2, 32'h3);

        // Randomized: non-MUL gaps then a MUL with mixed multiplier sizes
        for (int k = 0; k < 12; k++) begin
            int gap;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                logic [1:0] op;
                logic [5:0] f;
                next_cycle();
                op = 2'($urandom);
                f  = 6'($urandom);
                if (f == 6'b011000) f = 6'b100000;
                drive(1'($urandom), 1'($urandom), op, f);
                #1;
                chk("rnd_ctrl", bus.ALUCtrl_o, ref_ctrl(op, f));
                chk("rnd_stall", bus.stall_o, 1'b0);
                chk("rnd_sel", bus.sel_mul_o, 1'b0);
            end
            next_cycle();
            case (k % 3)
                0:       run_mul($urandom, $urandom);
                1:       run_mul($urandom, 32'($urandom_range(0, 255)));
                default: run_mul($urandom, (k == 5) ? 32'h0 : 32'($urandom_range(0, 65535)));
            endcase
        end

        next_cycle();
        drive(1'b0, 1'b0, 2'b00, 6'h0);
        #1;
        chk("final_sel", bus.sel_mul_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue side of the EX-stage ALU: decodes ALUOp/funct into the 3-bit ALU control code and drives the ALU's control input.
- The single-cycle ALU multiply is too slow for timing closure, so MUL runs here as an iterative shift-add over several cycles.
- While MUL runs, the block stalls the pipeline, then returns the product with a result-select strobe.
- Sits between the ID/EX pipeline register and the ALU / result mux.

Parameters:
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle; legal values 1, 2, 4; MUL_CYCLES = 32/BITS_PER_CYCLE.
- DATA_W, 32, operand/result width; fixed at 32 in this design.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- valid_i  in  1  ID/EX holds a live instruction
- flush_i  in  1  squash current EX instruction
- ALUOp_i  in  2  main-control op class
- funct_i  in  6  R-type funct field
- data1_i  in  32  operand A (post-forwarding)
- data2_i  in  32  operand B (post-forwarding)
- ALUCtrl_o  out  3  ALU control: ADD=000 SUB=001 AND=010 OR=011 MUL=100
- stall_o  out  1  hold PC, IF/ID and ID/EX
- mul_data_o  out  32  low 32 bits of data1_i*data2_i
- sel_mul_o  out  1  result mux selects mul_data_o instead of ALU data_o

Behaviour:
- Decode (combinational):
  - ALUOp 00 -> ADD; 01 -> SUB; 11 -> ADD.
  - ALUOp 10 uses funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 011000 MUL; any other funct -> ADD.
- ALUCtrl_o always shows the decoded code, including during MUL_RUN.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
- IDLE:
  - If valid_i & decoded MUL & !flush_i: stall_o=1 combinationally in the same cycle.
  - At that clock edge: latch A into the multiplicand register, B into the multiplier register, clear the accumulator and counter, go to MUL_RUN.
  - Otherwise stall_o=0 and the state stays IDLE.
- MUL_RUN:
  - stall_o=1.
  - Each cycle: acc += (low BITS_PER_CYCLE bits of multiplier) * multiplicand, all mod 2^32; multiplicand <<= BITS_PER_CYCLE; multiplier >>= BITS_PER_CYCLE; counter++.
  - After MUL_CYCLES cycles, go to MUL_DONE.
- MUL_DONE:
  - stall_o=0, sel_mul_o=1, mul_data_o=acc for exactly one cycle.
  - The instruction leaves EX at this edge; return to IDLE.
  - The same MUL still on the inputs in this cycle does not restart the multiply.
- Total latency: 1 issue cycle + MUL_CYCLES run cycles + 1 done cycle; stall_o high for MUL_CYCLES+1 cycles (33 at default).
- Back-to-back MULs: the second is decoded in the IDLE cycle after MUL_DONE, so there is no lost or merged operation.
- flush_i:
  - In MUL_RUN or MUL_DONE: next state IDLE, sel_mul_o forced 0 in that cycle, result discarded.
  - In IDLE: flush_i blocks a MUL start.
- Signedness: only the low 32 bits are produced, so the result is identical for signed and unsigned operands; overflow wraps silently.
- Operand changes on data*_i after the issue cycle are ignored (operands are latched).
- Reset (any time, including mid-multiply):
  - state IDLE; counter, accumulator and operand registers 0.
  - stall_o=0, sel_mul_o=0, mul_data_o=0.
  - ALUCtrl_o follows the decode of its inputs.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in MUL_RUN, when the shifted multiplier register is zero, go to MUL_DONE next cycle. The product is unchanged; the run phase shrinks to ceil(msb_index(B)+1 / BITS_PER_CYCLE) cycles, minimum 1 (B=0 -> one run cycle).
- Undefined: fixed MUL_CYCLES run cycles regardless of operand values.

Decomposition:
- Shared package alu_defs holds:
  - ALU control codes ADD/SUB/AND/OR/MUL (3-bit), shared with the ALU.
  - ALUOp encodings.
  - funct constants FUNCT_ADD/SUB/AND/OR/MUL.
  - FSM state encoding.
- One natural sub-module: mul_shift_add (operand registers, accumulator, counter, early-term detect).
- Decode logic and the FSM stay in the top level.

Test Plan:
- ALUOp=10, funct=100100, valid=1 -> ALUCtrl_o=010, stall_o=0, sel_mul_o=0 every cycle.
- funct=011000, A=0x00000007, B=0x00000006 -> stall_o high 33 cycles; next cycle sel_mul_o=1, mul_data_o=0x0000002A; stall_o low.
- A=0xFFFFFFFF, B=0xFFFFFFFF (i.e. -1*-1) -> mul_data_o=0x00000001. With MUL_EARLY_TERM_EN and A=5, B=1 -> stall_o high for 2 cycles, result 5.
- Two consecutive MULs (3*4 then 0x10000*0x10000) -> 12, then 0x00000000, each with its own full stall window and one sel_mul_o pulse.
- flush_i pulsed on cycle 10 of a MUL -> IDLE next cycle, no sel_mul_o pulse, stall_o drops.
- rst_i asserted on cycle 15 of MUL_RUN (asynchronously, mid-cycle) -> stall_o/sel_mul_o/mul_data_o go 0 immediately; after release a new MUL 2*3 yields 6.
